fib_tp_sync: RTL and testbench

FIB_TP_SYNC -- requirements
Module: fib_tp_sync

---
 rtl/fib_pkg.sv | 41 ++++
 rtl/tp_ack_sync.sv | 39 +++
 rtl/fib_tp_sync.sv | 181 ++++++++++++++++++
 tb/tb_fib_tp_sync.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: shared types and constants for the two-phase dual-rail
// Fibonacci-style sequence generator.
//   fib_state_e  - controller states (IDLE, EMIT, WAIT_ACK, DONE)
//   MODE_*       - overflow behaviour selectors
//   RAIL_*       - dual-rail encoding: RAIL_NUM rails per bit. A transition
//                  on RAIL_ONE carries a 1 and a transition on RAIL_ZERO
//                  carries a 0.
//   rail_advance - toggles the rail that encodes one bit value
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT     = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } fib_state_e;

    localparam int MODE_WRAP = 0;
    localparam int MODE_STOP = 1;

    localparam int RAIL_NUM  = 2;
    localparam int RAIL_ZERO = 0;
    localparam int RAIL_ONE  = 1;

    // Two-phase signalling: the rails are never returned to zero. Each token
    // flips exactly one rail of every bit.
    function automatic logic [RAIL_NUM-1:0] rail_advance(
        input logic [RAIL_NUM-1:0] rails,
        input logic                bit_v
    );
        logic [RAIL_NUM-1:0] r;
        r = rails;
        if (bit_v) begin
            r[RAIL_ONE] = ~rails[RAIL_ONE];
        end else begin
            r[RAIL_ZERO] = ~rails[RAIL_ZERO];
        end
        return r;
    endfunction

endpackage

// File: rtl/tp_ack_sync.sv
// tp_ack_sync: brings the consumer's two-phase acknowledge into the clk
// domain and flags every transition it sees.
//   clk      - sampling clock
//   rst_n    - asynchronous active-low reset; clears all three flops
//   ack_i    - asynchronous two-phase acknowledge (one toggle per token)
//   ack_edge - one-cycle flag: the synchronised level changed (rise or fall)
module tp_ack_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ack_i,
    output logic ack_edge
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = ack_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Two-phase protocol: either polarity of change is one acknowledge.
    assign ack_edge = sync_q ^ prev_q;

endmodule

// File: rtl/fib_tp_sync.sv
// fib_tp_sync: generates an ORDER-term additive sequence (2 = Fibonacci,
// 3 = tribonacci, ...) and delivers each term to an asynchronous consumer
// as a two-phase dual-rail token.
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - level-sampled request; accepted only in IDLE or DONE
//   n_terms    - number of terms to emit (0 = unbounded), latched on start
//   ack_i      - consumer acknowledge, one toggle per token
//   out        - dual-rail term, [bit][rail]
//   busy, done - sequence running / finished
//   ovf        - sticky overflow, cleared on accepted start
//   dbg_state  - current controller state (fib_state_e encoding)
//
// Handshake: a token is valid when every bit has flipped exactly one rail.
// The next token is not sent until one ack_i transition has been seen. Ack
// transitions that arrive while a token is being emitted are counted and
// used later, so none are lost. Ack transitions in IDLE and DONE are
// dropped.
module fib_tp_sync
    import fib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ORDER = 2,
    parameter int MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [15:0]            n_terms,
    input  logic                   ack_i,
    output logic [WIDTH-1:0][1:0]  out,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic [1:0]             dbg_state
);

    localparam int  SUM_W       = WIDTH + $clog2(ORDER);
    localparam bit  STOP_ON_OVF = (MODE == MODE_STOP);

    fib_state_e                          state_q, state_d;
    // hist_q[0] is the term emitted next. hist_q[ORDER-1] is the newest sum.
    logic [ORDER-1:0][WIDTH-1:0]         hist_q, hist_d;
    // hflag_q[i] marks a history entry whose sum overflowed when it was made.
    logic [ORDER-1:0]                    hflag_q, hflag_d;
    logic [WIDTH-1:0][RAIL_NUM-1:0]      rails_q, rails_d;
    logic [15:0]                         limit_q, limit_d;
    logic [15:0]                         emitted_q, emitted_d;
    logic [1:0]                          pend_q, pend_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                ovf_q, ovf_d;

    logic                                ack_edge;
    logic [SUM_W-1:0]                    sum;
    logic                                sum_ovf;
    logic [2:0]                          avail;

    tp_ack_sync u_ack_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ack_i    (ack_i),
        .ack_edge (ack_edge)
    );

    always_comb begin
        sum = '0;
        for (int i = 0; i < ORDER; i++) begin
            sum = sum + SUM_W'(hist_q[i]);
        end
        sum_ovf = |sum[SUM_W-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        hflag_d   = hflag_q;
        rails_d   = rails_q;
        limit_d   = limit_q;
        emitted_d = emitted_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        avail     = {1'b0, pend_q} + {2'b00, ack_edge};

        unique case (state_q)
            IDLE, DONE: begin
                // When start and an ack edge come together, the ack is
                // dropped and the start is taken.
                pend_d = '0;
                if (start) begin
                    for (int i = 0; i < ORDER; i++) begin
                        hist_d[i] = (i == ORDER - 1) ? WIDTH'(1) : '0;
                    end
                    hflag_d   = '0;
                    limit_d   = n_terms;
                    emitted_d = '0;
                    ovf_d     = 1'b0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = EMIT;
                end
            end

            EMIT: begin
                for (int b = 0; b < WIDTH; b++) begin
                    rails_d[b] = rail_advance(rails_q[b], hist_q[0][b]);
                end
                // Wrap mode: the truncated value goes out, and the flag is
                // raised when that value is emitted.
                if (hflag_q[0]) begin
                    ovf_d = 1'b1;
                end
                emitted_d = emitted_q + 16'd1;
                pend_d    = (avail > 3'd3) ? 2'd3 : avail[1:0];
                state_d   = WAIT_ACK;
            end

            WAIT_ACK: begin
                if (avail != 3'd0) begin
                    pend_d = 2'(avail - 3'd1);
                    if (limit_q != 16'd0 && emitted_q == limit_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (STOP_ON_OVF && hflag_q[1]) begin
                        // The next term would be an overflowed sum, so it is
                        // not sent.
                        ovf_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        for (int i = 0; i < ORDER - 1; i++) begin
                            hist_d[i]  = hist_q[i+1];
                            hflag_d[i] = hflag_q[i+1];
                        end
                        hist_d[ORDER-1]  = sum[WIDTH-1:0];
                        hflag_d[ORDER-1] = sum_ovf;
                        state_d          = EMIT;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hist_q    <= '0;
            hflag_q   <= '0;
            rails_q   <= '0;
            limit_q   <= '0;
            emitted_q <= '0;
            pend_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            hflag_q   <= hflag_d;
            rails_q   <= rails_d;
            limit_q   <= limit_d;
            emitted_q <= emitted_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out       = rails_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fib_tp_sync.sv
// tb_fib_tp_sync: three generator instances with WIDTH=8:
//   index 0: ORDER=2 wrap, index 1: ORDER=3 wrap, index 2: ORDER=2 stop.
// A sequence model builds the expected term list for each run. One monitor
// process decodes every rail change, compares it with the expected queue,
// and acts as the consumer by toggling ack_i.
module tb_fib_tp_sync;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    logic              start_v [3];
    logic [15:0]       nt_v    [3];
    logic              ack_v   [3];
    logic [W-1:0][1:0] out_v   [3];
    logic              busy_v  [3];
    logic              done_v  [3];
    logic              ovf_v   [3];
    logic [1:0]        dbg_v   [3];

    fib_tp_sync #(.WIDTH(W), .ORDER(2), .MODE(0)) u_fib (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .n_terms(nt_v[0]),
        .ack_i(ack_v[0]), .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .ovf(ovf_v[0]), .dbg_state(dbg_v[0]));

    fib_tp_sync #(.WIDTH(W), .ORDER(3), .MODE(0)) u_trib (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .n_terms(nt_v[1]),
        .ack_i(ack_v[1]), .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .ovf(ovf_v[1]), .dbg_state(dbg_v[1]));

    fib_tp_sync #(.WIDTH(W), .ORDER(2), .MODE(1)) u_stop (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .n_terms(nt_v[2]),
        .ack_i(ack_v[2]), .out(out_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .ovf(ovf_v[2]), .dbg_state(dbg_v[2]));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]      exp_q0[$];
    logic [W-1:0]      exp_q1[$];
    logic [W-1:0]      exp_q2[$];

    int                tok_cnt  [3];
    logic [W-1:0]      last_tok [3];
    logic [W-1:0][1:0] prev_out [3];
    logic              auto_ack [3];
    int                ack_cnt  [3];
    int                man_req  [3];

    // model results
    int m_terms [32];
    int m_cnt;
    int m_ovf;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Sequence from the definition: seeds 0..0,1, then each term is the sum
    // of the previous ORDER terms. A sum above 255 is an overflow: wrap keeps
    // the sum mod 256, stop ends the list before that term.
    task automatic model_seq(input int order, input int mode, input int n);
        int s;
        m_cnt = 0;
        m_ovf = 0;
        for (int k = 0; k < 32; k++) begin
            if (n != 0 && k >= n) break;
            if (k < order) begin
                s = (k == order - 1) ? 1 : 0;
            end else begin
                s = 0;
                for (int j = 1; j <= order; j++) s += m_terms[k - j];
                if (s > 255) begin
                    m_ovf = 1;
                    if (mode == 1) break;
                    s = s % 256;
                end
            end
            m_terms[k] = s;
            m_cnt++;
        end
    endtask

    task automatic push_exp(input int i, input logic [W-1:0] v);
        case (i)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int i, output logic ok, output logic [W-1:0] v);
        ok = 1'b0;
        v  = '0;
        case (i)
            0: if (exp_q0.size() > 0) begin ok = 1'b1; v = exp_q0.pop_front(); end
            1: if (exp_q1.size() > 0) begin ok = 1'b1; v = exp_q1.pop_front(); end
            default: if (exp_q2.size() > 0) begin ok = 1'b1; v = exp_q2.pop_front(); end
        endcase
    endtask

    function automatic int exp_size(input int i);
        case (i)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    // ---------------- compare + consumer ----------------
    initial begin : monitor
        logic [W-1:0] val;
        logic [W-1:0] ev;
        logic [1:0]   d;
        logic         bad;
        logic         ok;
        logic         toggled;
        for (int i = 0; i < 3; i++) begin
            prev_out[i] = '0;
            ack_cnt[i]  = 0;
            tok_cnt[i]  = 0;
            last_tok[i] = '0;
            ack_v[i]    = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    prev_out[i] = out_v[i];
                    ack_cnt[i]  = 0;
                    man_req[i]  = 0;
                end else begin
                    if (out_v[i] != prev_out[i]) begin
                        bad = 1'b0;
                        val = '0;
                        for (int b = 0; b < W; b++) begin
                            d = out_v[i][b] ^ prev_out[i][b];
                            if (d == 2'b10) val[b] = 1'b1;
                            else if (d != 2'b01) bad = 1'b1;
                        end
                        check("rail_encoding", bad, 0);
                        pop_exp(i, ok, ev);
                        check("token_expected", ok, 1);
                        if (ok) check("token_value", val, ev);
                        tok_cnt[i]++;
                        last_tok[i] = val;
                        prev_out[i] = out_v[i];
                        if (auto_ack[i]) ack_cnt[i] = 5;
                    end
                    toggled = 1'b0;
                    if (ack_cnt[i] > 0) begin
                        ack_cnt[i]--;
                        if (ack_cnt[i] == 0) begin
                            ack_v[i] = ~ack_v[i];
                            toggled  = 1'b1;
                        end
                    end
                    if (!toggled && man_req[i] > 0) begin
                        ack_v[i] = ~ack_v[i];
                        man_req[i]--;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_tokens(input int i, input int target, input int budget,
                               input string name);
        int c;
        c = 0;
        while (tok_cnt[i] < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, int'(tok_cnt[i] >= target), 1);
    endtask

    task automatic run_seq(input int i, input int order, input int mode,
                           input int n, input int budget);
        logic [W-1:0][1:0] pre;
        int base;
        int c;
        model_seq(order, mode, n);
        for (int k = 0; k < m_cnt; k++) push_exp(i, W'(m_terms[k]));
        base = tok_cnt[i];
        @(negedge clk);
        pre        = out_v[i];
        nt_v[i]    = 16'(n);
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        check("first_tok_not_early", int'(out_v[i] != pre), 0);
        @(posedge clk);
        #1;
        check("first_tok_latency", int'(out_v[i] != pre), 1);
        check("busy_running", busy_v[i], 1);
        c = 0;
        while (!done_v[i] && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_in_budget", done_v[i], 1);
        repeat (12) @(negedge clk);
        check("token_count", tok_cnt[i] - base, m_cnt);
        check("queue_drained", exp_size(i), 0);
        check("done_held", done_v[i], 1);
        check("busy_clear", busy_v[i], 0);
        check("ovf_final", ovf_v[i], m_ovf);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int base;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i]  = 1'b0;
            nt_v[i]     = '0;
            auto_ack[i] = 1'b1;
            man_req[i]  = 0;
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_out_zero", out_v[i], 0);
            check("rst_busy", busy_v[i], 0);
            check("rst_done", done_v[i], 0);
            check("rst_ovf", ovf_v[i], 0);
            check("rst_state", dbg_v[i], 0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("idle_no_tokens", tok_cnt[i], 0);
            check("idle_busy", busy_v[i], 0);
        end

        // Hand-computed values that pin the model itself.
        model_seq(2, 0, 6);
        check("pin_fib_cnt", m_cnt, 6);
        check("pin_fib_t3", m_terms[3], 2);
        check("pin_fib_t5", m_terms[5], 5);
        check("pin_fib_ovf", m_ovf, 0);
        model_seq(3, 0, 7);
        check("pin_trib_t1", m_terms[1], 0);
        check("pin_trib_t5", m_terms[5], 4);
        check("pin_trib_t6", m_terms[6], 7);
        model_seq(2, 1, 0);
        check("pin_stop_cnt", m_cnt, 14);
        check("pin_stop_last", m_terms[13], 233);
        check("pin_stop_ovf", m_ovf, 1);
        model_seq(2, 0, 15);
        check("pin_wrap_t14", m_terms[14], 121);
        check("pin_wrap_ovf", m_ovf, 1);

        // Fibonacci, 6 terms.
        run_seq(0, 2, 0, 6, 300);
        check("fib6_last", last_tok[0], 5);

        // Tribonacci, 7 terms.
        run_seq(1, 3, 0, 7, 300);
        check("trib7_last", last_tok[1], 7);

        // Stop on overflow, unbounded.
        run_seq(2, 2, 1, 0, 500);
        check("stop_last", last_tok[2], 233);
        check("stop_ovf", ovf_v[2], 1);

        // Wrap on overflow, 15 terms, restarted from DONE on instance 0.
        run_seq(0, 2, 0, 15, 500);
        check("wrap_last", last_tok[0], 121);
        repeat (8) @(negedge clk);
        check("wrap_ovf_held", ovf_v[0], 1);

        // Start ignored in WAIT_ACK; two close ack toggles give two tokens.
        auto_ack[0] = 1'b0;
        model_seq(2, 0, 5);
        for (int k = 0; k < m_cnt; k++) push_exp(0, W'(m_terms[k]));
        base = tok_cnt[0];
        @(negedge clk);
        nt_v[0]    = 16'd5;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_tokens(0, base + 1, 20, "burst_first_tok");
        check("burst_wait_state", dbg_v[0], 2);
        @(negedge clk);
        nt_v[0]    = 16'd2;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("burst_start_ignored", busy_v[0], 1);
        man_req[0] = 2;
        wait_tokens(0, base + 3, 40, "burst_two_tokens");
        repeat (10) @(negedge clk);
        check("burst_no_extra", tok_cnt[0] - base, 3);
        auto_ack[0] = 1'b1;
        man_req[0]  = 1;
        begin
            int c;
            c = 0;
            while (!done_v[0] && c < 200) begin
                @(negedge clk);
                c++;
            end
        end
        check("burst_done", done_v[0], 1);
        repeat (12) @(negedge clk);
        check("burst_token_count", tok_cnt[0] - base, 5);
        check("burst_queue_drained", exp_size(0), 0);

        // Reset in the middle of a sequence, then a short restart.
        model_seq(2, 0, 6);
        for (int k = 0; k < m_cnt; k++) push_exp(0, W'(m_terms[k]));
        base = tok_cnt[0];
        @(negedge clk);
        nt_v[0]    = 16'd6;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_tokens(0, base + 3, 80, "pre_reset_progress");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rails_zero", out_v[0], 0);
        check("mid_rst_busy", busy_v[0], 0);
        check("mid_rst_done", done_v[0], 0);
        check("mid_rst_ovf", ovf_v[0], 0);
        exp_q0.delete();
        repeat (2) @(negedge clk);
        check("mid_rst_rails_held", out_v[0], 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_state", dbg_v[0], 0);
        check("post_rst_busy", busy_v[0], 0);
        run_seq(0, 2, 0, 2, 100);
        check("restart_last", last_tok[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
